spi_master_param: RTL and testbench

//  Parametrised SPI master, next generation of the CPU-side SPI controller. Serialises
//  1..DATA_W bits per transfer on one of NUM_CS slave selects, in all four CPOL/CPHA modes,
//  MSB- or LSB-first. Sits between the RISC-V register interface and the pads; raises a

---
 rtl/spi_master_param.sv | 199 +++++++++++++++++++
 tb/tb_spi_master_param.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parametrised SPI master: 1..DATA_W bits per transfer, all CPOL/CPHA modes, MSB/LSB first.
// Define SPI_LOOPBACK_EN to let spi_loop feed internal MOSI into the receive shifter.
module spi_master_param #(
    parameter int DATA_W = 32,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 16
) (
    input  logic                                         clk_cpu,
    input  logic                                         rst,
    input  logic [DIV_W-1:0]                             SPI_BITRATE,
    input  logic [DATA_W-1:0]                            SPI_DATA_OUT,
    output logic [DATA_W-1:0]                            SPI_DATA_IN,
    input  logic                                         start,
    input  logic [$clog2(DATA_W):0]                      xfer_len,
    input  logic                                         cpol,
    input  logic                                         cpha,
    input  logic                                         lsb_first,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
    input  logic                                         irq_en,
    input  logic                                         irq_clr,
    input  logic                                         spi_loop,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         interrpt,
    output logic                                         SCK,
    output logic                                         MOSI,
    input  logic                                         MISO,
    output logic [NUM_CS-1:0]                            SS
);

    localparam int LW  = $clog2(DATA_W) + 1;
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EW  = LW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

    state_e            state_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [LW-1:0]     len_q;
    logic [EW-1:0]     edge_q;
    logic              cpha_q;
    logic              lsb_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] din_q;
    logic              sck_q;
    logic              mosi_q;
    logic              miso_q;
    logic              busy_q;
    logic              done_q;
    logic              irq_q;
    logic [NUM_CS-1:0] ss_q;

    logic [LW-1:0]     len_d;
    logic [NUM_CS-1:0] ss_sel_d;
    logic              first_bit_d;
    logic              tick;
    logic              last_edge;
    logic              hold_done;
    logic [EW-1:0]     edge_n;
    logic              is_sample;
    logic [LW-1:0]     samp_pos;
    logic [LW-1:0]     drv_pos;
    logic [LW-1:0]     samp_idx;
    logic [LW-1:0]     drv_idx;
    logic              drv_valid;
    logic              tx_bit;
    logic              rx_bit;

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = spi_loop ? mosi_q : miso_q;
`else
    logic unused_loop;
    assign unused_loop = spi_loop;
    assign rx_bit      = miso_q;
`endif

    // A zero or oversized length means a full-width transfer.
    assign len_d = (xfer_len == '0 || xfer_len > LW'(DATA_W)) ? LW'(DATA_W) : xfer_len;

    always_comb begin
        ss_sel_d = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            ss_sel_d[i] = (NUM_CS == 1) || (cs_sel == CSW'(i));
        end
    end

    assign first_bit_d = |(SPI_DATA_OUT &
                           (DATA_W'(1) << (lsb_first ? LW'(0) : len_d - LW'(1))));

    assign tick      = (cnt_q == div_q);
    assign last_edge = (edge_q == {len_q, 1'b0} - EW'(1));
    assign hold_done = (state_q == HOLD) && tick;

    // Edge 0 is produced on leaving SETUP; even edges are leading, odd edges trailing.
    always_comb begin
        edge_n    = (state_q == SETUP) ? '0 : edge_q + EW'(1);
        is_sample = (edge_n[0] == cpha_q);
        samp_pos  = LW'(edge_n >> 1);
        drv_pos   = cpha_q ? LW'(edge_n >> 1) : LW'((edge_n + EW'(1)) >> 1);
        drv_valid = (drv_pos < len_q);
        samp_idx  = lsb_q ? samp_pos : len_q - LW'(1) - samp_pos;
        drv_idx   = lsb_q ? drv_pos : len_q - LW'(1) - drv_pos;
        tx_bit    = |(tx_q & (DATA_W'(1) << drv_idx));
    end

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            edge_q  <= '0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            din_q   <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            ss_q    <= '1;
        end else begin
            miso_q <= MISO;
            done_q <= 1'b0;
            if (hold_done && irq_en) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    sck_q <= cpol;
                    cnt_q <= '0;
                    if (start) begin
                        state_q <= SETUP;
                        busy_q  <= 1'b1;
                        div_q   <= SPI_BITRATE;
                        len_q   <= len_d;
                        cpha_q  <= cpha;
                        lsb_q   <= lsb_first;
                        tx_q    <= SPI_DATA_OUT;
                        rx_q    <= '0;
                        edge_q  <= '0;
                        ss_q    <= ~ss_sel_d;
                        mosi_q  <= cpha ? 1'b0 : first_bit_d;
                    end
                end
                SETUP, XFER: begin
                    if (!tick) begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end else begin
                        cnt_q <= '0;
                        if (state_q == XFER && last_edge) begin
                            state_q <= HOLD;
                        end else begin
                            state_q <= XFER;
                            sck_q   <= ~sck_q;
                            edge_q  <= edge_n;
                            if (is_sample) begin
                                rx_q <= rx_q | (DATA_W'(rx_bit) << samp_idx);
                            end else if (drv_valid) begin
                                mosi_q <= tx_bit;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!tick) begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end else begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        ss_q    <= '1;
                        din_q   <= rx_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        mosi_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SPI_DATA_IN = din_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign interrpt    = irq_q;
    assign SCK         = sck_q;
    assign MOSI        = mosi_q;
    assign SS          = ss_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: a behavioural SPI slave drives MISO and records
// MOSI on every sample edge, and expectations come from the transfer rules with plain arithmetic.
module tb_spi_master_param;

    localparam int DATA_W = 32;
    localparam int NUM_CS = 4;
    localparam int DIV_W  = 16;

    logic              clk_cpu;
    logic              rst;
    logic [DIV_W-1:0]  SPI_BITRATE;
    logic [DATA_W-1:0] SPI_DATA_OUT;
    logic [DATA_W-1:0] SPI_DATA_IN;
    logic              start;
    logic [5:0]        xfer_len;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [1:0]        cs_sel;
    logic              irq_en;
    logic              irq_clr;
    logic              spi_loop;
    logic              busy;
    logic              done;
    logic              interrpt;
    logic              SCK;
    logic              MOSI;
    logic              MISO;
    logic [NUM_CS-1:0] SS;

    // Second instance with three selects, permanently addressing a non-existent slave.
    logic [1:0]        cs_sel3;
    logic [DATA_W-1:0] SPI_DATA_IN3;
    logic              busy3;
    logic              done3;
    logic              interrpt3;
    logic              SCK3;
    logic              MOSI3;
    logic [2:0]        SS3;

    int   testCount;
    int   failCount;
    logic irqExp;

    spi_master_param #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
        .clk_cpu(clk_cpu), .rst(rst), .SPI_BITRATE(SPI_BITRATE), .SPI_DATA_OUT(SPI_DATA_OUT),
        .SPI_DATA_IN(SPI_DATA_IN), .start(start), .xfer_len(xfer_len), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cs_sel(cs_sel), .irq_en(irq_en), .irq_clr(irq_clr),
        .spi_loop(spi_loop), .busy(busy), .done(done), .interrpt(interrpt), .SCK(SCK),
        .MOSI(MOSI), .MISO(MISO), .SS(SS)
    );

    spi_master_param #(.DATA_W(DATA_W), .NUM_CS(3), .DIV_W(DIV_W)) dut3 (
        .clk_cpu(clk_cpu), .rst(rst), .SPI_BITRATE(SPI_BITRATE), .SPI_DATA_OUT(SPI_DATA_OUT),
        .SPI_DATA_IN(SPI_DATA_IN3), .start(start), .xfer_len(xfer_len), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cs_sel(cs_sel3), .irq_en(irq_en), .irq_clr(irq_clr),
        .spi_loop(spi_loop), .busy(busy3), .done(done3), .interrpt(interrpt3), .SCK(SCK3),
        .MOSI(MOSI3), .MISO(MISO), .SS(SS3)
    );

    initial begin
        clk_cpu = 1'b0;
        forever #5 clk_cpu = ~clk_cpu;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Bit p of the serial sequence, taken from a right-justified word of n bits.
    function automatic logic seqBit(input logic [31:0] w, input int p, input int n,
                                    input logic lsb);
        return lsb ? w[p] : w[n-1-p];
    endfunction

    task automatic applyStimulus(input string tag, input logic [15:0] br,
                                 input logic [31:0] outWord, input logic [5:0] len,
                                 input logic mCpol, input logic mCpha, input logic mLsb,
                                 input logic [1:0] cs, input logic [31:0] misoWord,
                                 input logic loop, input logic ien, input logic clrDuring,
                                 input logic injectStart);
        int          lenEff;
        int          expLat;
        int          cycles;
        int          nSamp;
        int          slavePos;
        int          ssErr;
        int          ss3Err;
        int          extraDone;
        logic [31:0] expSeq;
        logic [31:0] obsSeq;
        logic [31:0] mask;
        logic [31:0] expIn;
        logic [3:0]  expSs;
        logic        prevSck;
        logic        leading;
        logic        doneSeen;
        logic        useLoop;
        logic        newIrq;
        logic        done3Seen;

        lenEff = (len == 6'd0 || len > 6'd32) ? 32 : int'(len);
        mask   = (lenEff == 32) ? 32'hFFFF_FFFF : ((32'd1 << lenEff) - 32'd1);
        expSeq = '0;
        obsSeq = '0;
        for (int p = 0; p < lenEff; p++) expSeq[p] = seqBit(outWord, p, lenEff, mLsb);
        expLat = (2 * lenEff + 2) * (int'(br) + 1);
        expSs  = 4'hF;
        expSs[cs] = 1'b0;
`ifdef SPI_LOOPBACK_EN
        useLoop = loop;
`else
        useLoop = 1'b0;
`endif
        expIn  = useLoop ? (outWord & mask) : (misoWord & mask);
        newIrq = ien ? 1'b1 : (clrDuring ? 1'b0 : irqExp);

        @(negedge clk_cpu);
        SPI_BITRATE  = br;
        SPI_DATA_OUT = outWord;
        xfer_len     = len;
        cpol         = mCpol;
        cpha         = mCpha;
        lsb_first    = mLsb;
        cs_sel       = cs;
        irq_en       = ien;
        spi_loop     = loop;
        MISO         = seqBit(misoWord, 0, lenEff, mLsb);
        repeat (2) @(negedge clk_cpu);
        checkOutput({tag, ".sck_idle"}, SCK, mCpol);
        checkOutput({tag, ".busy_idle"}, busy, 1'b0);
        start   = 1'b1;
        irq_clr = clrDuring;
        @(negedge clk_cpu);
        start = 1'b0;
        checkOutput({tag, ".busy_rise"}, busy, 1'b1);

        cycles    = 0;
        nSamp     = 0;
        ssErr     = 0;
        ss3Err    = 0;
        doneSeen  = 1'b0;
        done3Seen = 1'b0;
        prevSck   = SCK;
        slavePos  = mCpha ? 0 : 1;
        if (SS !== expSs) ssErr++;
        if (SS3 !== 3'b111) ss3Err++;
        while (!doneSeen && cycles < expLat + 20) begin
            @(negedge clk_cpu);
            cycles++;
            if (injectStart && cycles == 7) begin
                start        = 1'b1;
                SPI_DATA_OUT = ~outWord;
                xfer_len     = 6'd3;
                SPI_BITRATE  = br + 16'd1;
                lsb_first    = ~mLsb;
            end
            if (injectStart && cycles == 8) start = 1'b0;
            if (done) begin
                doneSeen  = 1'b1;
                done3Seen = done3;
            end else begin
                if (busy && SS !== expSs) ssErr++;
                if (SS3 !== 3'b111) ss3Err++;
                if (SCK !== prevSck) begin
                    leading = (SCK !== mCpol);
                    if (leading != mCpha) begin
                        if (nSamp < 32) obsSeq[nSamp] = MOSI;
                        nSamp++;
                    end else begin
                        if (slavePos < lenEff) MISO = seqBit(misoWord, slavePos, lenEff, mLsb);
                        slavePos++;
                    end
                    prevSck = SCK;
                end
            end
        end

        checkOutput({tag, ".done_seen"}, doneSeen, 1'b1);
        checkOutput({tag, ".latency"}, cycles, expLat);
        checkOutput({tag, ".samples"}, nSamp, lenEff);
        checkOutput({tag, ".mosi_seq"}, obsSeq, expSeq);
        checkOutput({tag, ".ss_during"}, ssErr, 0);
        checkOutput({tag, ".ss3_high"}, ss3Err, 0);
        checkOutput({tag, ".done3"}, done3Seen, 1'b1);
        checkOutput({tag, ".data_in"}, SPI_DATA_IN, expIn);
        checkOutput({tag, ".data_in3"}, SPI_DATA_IN3, expIn);
        checkOutput({tag, ".busy_fall"}, busy, 1'b0);
        checkOutput({tag, ".ss_release"}, SS, 4'hF);
        checkOutput({tag, ".irq"}, interrpt, newIrq);
        irqExp  = newIrq;
        irq_clr = 1'b0;

        extraDone = 0;
        repeat (3) begin
            @(negedge clk_cpu);
            if (done) extraDone++;
        end
        checkOutput({tag, ".extra_done"}, extraDone, 0);
        checkOutput({tag, ".sck_after"}, SCK, mCpol);
    endtask

    initial begin
        int   edges;
        logic prev;

        testCount    = 0;
        failCount    = 0;
        irqExp       = 1'b0;
        rst          = 1'b0;
        SPI_BITRATE  = '0;
        SPI_DATA_OUT = '0;
        start        = 1'b0;
        xfer_len     = '0;
        cpol         = 1'b0;
        cpha         = 1'b0;
        lsb_first    = 1'b0;
        cs_sel       = '0;
        cs_sel3      = 2'd3;
        irq_en       = 1'b0;
        irq_clr      = 1'b0;
        spi_loop     = 1'b0;
        MISO         = 1'b0;

        #2 rst = 1'b1;
        #1;
        checkOutput("reset.ss", SS, 4'hF);
        checkOutput("reset.sck", SCK, 1'b0);
        checkOutput("reset.mosi", MOSI, 1'b0);
        checkOutput("reset.data_in", SPI_DATA_IN, 32'h0);
        checkOutput("reset.busy", busy, 1'b0);
        checkOutput("reset.done", done, 1'b0);
        checkOutput("reset.irq", interrpt, 1'b0);
        repeat (2) @(negedge clk_cpu);
        rst = 1'b0;

        applyStimulus("t1_mode0", 16'd2, 32'h0000_00A5, 6'd8, 1'b0, 1'b0, 1'b0, 2'd0,
                      32'h0000_003C, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("t2_mode3", 16'd1, 32'h8000_0001, 6'd32, 1'b1, 1'b1, 1'b1, 2'd1,
                      32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("t3_cs2", 16'd2, 32'h0000_003C, 6'd8, 1'b0, 1'b1, 1'b0, 2'd2,
                      32'h0000_00C3, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("t4_irq", 16'd1, 32'h0000_1234, 6'd16, 1'b1, 1'b0, 1'b0, 2'd3,
                      32'h0000_ABCD, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk_cpu);
        irq_clr = 1'b1;
        @(negedge clk_cpu);
        irq_clr = 1'b0;
        checkOutput("t4_irq.cleared", interrpt, 1'b0);
        irqExp = 1'b0;
        applyStimulus("t4_setwins", 16'd1, 32'h0000_0055, 6'd7, 1'b0, 1'b1, 1'b1, 2'd0,
                      32'h0000_002A, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("br0", 16'd0, 32'h0000_0013, 6'd5, 1'b1, 1'b0, 1'b0, 2'd3,
                      32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("len0", 16'd1, 32'h1357_9BDF, 6'd0, 1'b0, 1'b0, 1'b1, 2'd1,
                      32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("len40", 16'd1, 32'hF0E1_D2C3, 6'd40, 1'b1, 1'b1, 1'b0, 2'd2,
                      32'h0F1E_2D3C, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort a transfer with reset right after the third SCK edge.
        @(negedge clk_cpu);
        SPI_BITRATE  = 16'd2;
        SPI_DATA_OUT = 32'hFFFF_FFFF;
        xfer_len     = 6'd8;
        cpol         = 1'b0;
        cpha         = 1'b0;
        lsb_first    = 1'b0;
        cs_sel       = 2'd1;
        irq_en       = 1'b1;
        start        = 1'b1;
        @(negedge clk_cpu);
        start = 1'b0;
        edges = 0;
        prev  = SCK;
        for (int c = 0; c < 100 && edges < 3; c++) begin
            @(negedge clk_cpu);
            if (SCK !== prev) begin
                edges++;
                prev = SCK;
            end
        end
        checkOutput("rstmid.edges", edges, 3);
        checkOutput("rstmid.busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstmid.ss", SS, 4'hF);
        checkOutput("rstmid.sck", SCK, 1'b0);
        checkOutput("rstmid.busy", busy, 1'b0);
        checkOutput("rstmid.data_in", SPI_DATA_IN, 32'h0);
        checkOutput("rstmid.mosi", MOSI, 1'b0);
        checkOutput("rstmid.irq", interrpt, 1'b0);
        irqExp = 1'b0;
        @(negedge clk_cpu);
        rst = 1'b0;

        applyStimulus("recover", 16'd2, 32'h0000_0F0F, 6'd12, 1'b0, 1'b1, 1'b0, 2'd0,
                      32'h0000_0ABC, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SPI_LOOPBACK_EN
        applyStimulus("loop", 16'd2, 32'h0000_005A, 6'd8, 1'b0, 1'b0, 1'b0, 2'd0,
                      32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("rand%0d", i), 16'($urandom_range(1, 3)), $urandom,
                          6'($urandom_range(0, 40)), 1'($urandom), 1'($urandom), 1'($urandom),
                          2'($urandom), $urandom, 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
